// File: rtl/serv_rf_ram_ctrl.sv
// Bit-serial register file sequencer over a W-bit simple-dual-port RAM.
// Optional SERV_RF_X0_GUARD_EN: suppress rd==0 writes and read x0 as zero.
module serv_rf_ram_ctrl #(
    parameter int W = 8,
    localparam int CW = $clog2(32 / W)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rreq,
    input  logic [5:0]      i_rreg0,
    input  logic [5:0]      i_rreg1,
    input  logic [5:0]      i_wreg0,
    input  logic            i_wen0,
    input  logic            i_wdata0,
    output logic            o_ready,
    output logic            o_rvalid,
    output logic            o_rdata0,
    output logic            o_rdata1,
    output logic [5+CW:0]   o_raddr,
    output logic            o_ren,
    input  logic [W-1:0]    i_rdata,
    output logic [5+CW:0]   o_waddr,
    output logic [W-1:0]    o_wdata,
    output logic            o_wen
);

    localparam int PW  = $clog2(W);
    localparam int CWI = (CW > 0) ? CW : 1;
    localparam logic [CWI-1:0] LAST = CWI'((32 / W) - 1);

    typedef enum logic [2:0] {IDLE, PRE0, PRE1, PRE2, RUN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [4:0]       cnt;
    logic [5:0]       rs1;
    logic [5:0]       rs2;
    logic [5:0]       rd;
    logic [W-1:0]     hold1;
    logic [W-1:0]     hold2;
    logic [W-1:0]     sr1;
    logic [W-1:0]     sr2;
    logic [W-1:0]     wbuf;
    logic [CWI-1:0]   k;
    logic [PW-1:0]    p;
    logic             last_k;
    logic             p_end;
    logic             ren;
    logic [5:0]       rreg;
    logic [CWI-1:0]   rchunk;
    logic             wr_ok;

    assign k      = CWI'(cnt >> PW);
    assign p      = cnt[PW-1:0];
    assign last_k = (k == LAST);
    assign p_end  = &p;

`ifdef SERV_RF_X0_GUARD_EN
    assign wr_ok    = i_wen0 & (|rd);
    assign o_rdata0 = o_rvalid & sr1[0] & (|rs1);
    assign o_rdata1 = o_rvalid & sr2[0] & (|rs2);
`else
    assign wr_ok    = i_wen0;
    assign o_rdata0 = o_rvalid & sr1[0];
    assign o_rdata1 = o_rvalid & sr2[0];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ren      = 1'b0;
        rreg     = rs1;
        rchunk   = '0;
        unique case (state)
            IDLE: if (i_rreq) state_nx = PRE0;
            PRE0: begin
                ren      = 1'b1;
                state_nx = PRE1;
            end
            PRE1: begin
                ren      = 1'b1;
                rreg     = rs2;
                state_nx = PRE2;
            end
            PRE2: state_nx = RUN;
            RUN: begin
                // prefetch the next chunk early in the current one
                if (!last_k && p == PW'(0)) begin
                    ren    = 1'b1;
                    rchunk = CWI'(k + 1'b1);
                end
                if (!last_k && p == PW'(1)) begin
                    ren    = 1'b1;
                    rreg   = rs2;
                    rchunk = CWI'(k + 1'b1);
                end
                if (cnt == 5'd31) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_ren    = ren;
    assign o_raddr  = ren ? (6+CW)'({rreg, rchunk} >> (CWI - CW)) : '0;
    assign o_ready  = (state == PRE2);
    assign o_rvalid = (state == RUN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            hold1   <= '0;
            hold2   <= '0;
            sr1     <= '0;
            sr2     <= '0;
            wbuf    <= '0;
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            o_wen <= 1'b0;
            if (state == IDLE && i_rreq) begin
                rs1 <= i_rreg0;
                rs2 <= i_rreg1;
                rd  <= i_wreg0;
            end
            if (state == PRE1) hold1 <= i_rdata;
            if (state == PRE2) begin
                sr1 <= hold1;
                sr2 <= i_rdata;
            end
            if (state == RUN) begin
                cnt  <= cnt + 5'd1;
                wbuf <= {i_wdata0, wbuf[W-1:1]};
                if (!last_k && p == PW'(1)) hold1 <= i_rdata;
                if (!last_k && p == PW'(2)) hold2 <= i_rdata;
                if (p_end) begin
                    sr1     <= hold1;
                    sr2     <= hold2;
                    o_wen   <= wr_ok;
                    o_waddr <= (6+CW)'({rd, k} >> (CWI - CW));
                    o_wdata <= {i_wdata0, wbuf[W-1:1]};
                end else begin
                    sr1 <= sr1 >> 1;
                    sr2 <= sr2 >> 1;
                end
            end
        end
    end

endmodule

// File: doc/serv_rf_ram_ctrl.md
# serv_rf_ram_ctrl

Sequencer between the bit-serial register-file port and a W-bit simple-dual-port RAM (1-cycle registered read, separate write port). Once per register access phase it prefetches rs1/rs2 chunks and streams them one bit per cycle for 32 cycles. In the same 32 cycles it packs the serial rd write stream into W-bit RAM writes. Register address space is 6 bits: 32 GPRs plus CSR/trap slots.

## Interface
- W, 8, RAM data width; legal values 4, 8, 16, 32. CW = log2(32/W) is the chunk-index width.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rreq  in  1  start an access phase; accepted in IDLE only
- i_rreg0  in  6  rs1 register, sampled on accept
- i_rreg1  in  6  rs2 register, sampled on accept
- i_wreg0  in  6  rd register, sampled on accept
- i_wen0  in  1  rd write enable, per bit during RUN
- i_wdata0  in  1  rd serial data, LSB first
- o_ready  out  1  high the cycle before the first streamed bit
- o_rvalid  out  1  high during the 32 streaming cycles
- o_rdata0  out  1  rs1 serial bit, LSB first
- o_rdata1  out  1  rs2 serial bit, LSB first
- o_raddr  out  6+CW  RAM read address {reg, chunk}
- o_ren  out  1  RAM read enable
- i_rdata  in  W  RAM read data, valid the cycle after o_ren
- o_waddr  out  6+CW  RAM write address {reg, chunk}
- o_wdata  out  W  RAM write data
- o_wen  out  1  RAM write enable

## Operation
- States: IDLE -> PRE0 -> PRE1 -> PRE2 -> RUN (32 cycles) -> IDLE.
- IDLE: on i_rreq, latch rs1/rs2/rd and go to PRE0. i_rreq is ignored in every other state.
- PRE0: read {rs1,0}.
- PRE1: read {rs2,0}; capture i_rdata into hold1.
- PRE2: o_ready=1. At cycle end, load shift register 1 from hold1 and shift register 2 from i_rdata.
- RUN: 5-bit counter c runs 0..31. Chunk index k=c/W. Phase p=c%W.
  - o_rdata0/1 are the LSBs of the shift registers; both registers shift right every cycle.
  - For k<32/W-1: p=0 reads {rs1,k+1}; p=1 reads {rs2,k+1}. Capture hold1 at the end of p=1 and hold2 at the end of p=2.
  - At the end of p=W-1, reload both shift registers from hold1 and hold2.
  - No reads are issued in the last chunk.
- Write path:
  - Each RUN cycle, i_wdata0 shifts into wbuf at the MSB.
  - At the end of p=W-1, if i_wen0=1, the next cycle drives o_wen=1, o_waddr={rd,k}, o_wdata=wbuf.
  - The last chunk's write lands in the first cycle after RUN. It proceeds independent of state.
- Reads lead writes on every chunk, so rd==rs1 or rd==rs2 returns the old value.
- Reset values: state IDLE, c=0, and o_ready, o_rvalid, o_ren, o_wen, o_rdata0, o_rdata1 all 0. Addresses and data are 0.
- Reset mid-RUN aborts at once. Any pending chunk write is dropped. Chunks already written stay in RAM.

## Timing
- i_rreq at cycle t:
  - PRE0 at t+1
  - o_ready at t+3
  - bit 0 on o_rdata0/1 at t+4
  - bit 31 at t+35
  - IDLE at t+36
- The earliest next accept is a request seen at t+36, which streams from t+40.
- Final-chunk write occurs at t+36.
- Read rate: exactly 2 RAM reads per W cycles. Write rate: at most 1 RAM write per W cycles.

## Configuration
- SERV_RF_X0_GUARD_EN defined:
  - RAM writes with rd==0 are suppressed.
  - o_rdata0/o_rdata1 are forced to 0 when the latched rs1/rs2 is 0, respectively.
- Undefined: no guard. Register 0 behaves as ordinary RAM, and the upstream logic keeps it zero.

## Test plan
- Preload {5} with 0xDEADBEEF and {9} with 0x12345678. Access with rs1=5, rs2=9 -> o_ready at t+3; o_rdata0 streams 0xDEADBEEF and o_rdata1 streams 0x12345678, LSB first, t+4..t+35.
- rd=3, i_wen0=1, stream 0xA5A5F00F (W=8) -> 4 writes: {3,0}=0x0F at t+12, {3,1}=0xF0 at t+20, {3,2}=0xA5 at t+28, {3,3}=0xA5 at t+36.
- rs1=rd=7, old value 0x1, write 0xFFFFFFFF -> stream shows 0x00000001; a follow-up access reads 0xFFFFFFFF.
- i_rreq held high continuously -> accepts at t and t+36 only; exactly 2 RUN windows of 32 cycles in 72 cycles.
- Assert i_rst_n low at c=13 -> all outputs 0 asynchronously; no o_wen afterwards; chunk {rd,0} is updated and chunk {rd,1} is unchanged.
- With SERV_RF_X0_GUARD_EN: rd=0, i_wen0=1 -> o_wen never asserted; rs1=0 -> o_rdata0=0 for all 32 bits even if RAM {0} is nonzero.
